bin2bcd_serial: RTL and testbench
=================================

Name: bin2bcd_serial

Overview:
- Sequential shift-and-add-3 (double-dabble) converter from unsigned binary to packed BCD.
- Sits directly upstream of the per-digit BCD threshold/compare logic in the combination-logic library.
- Each 4-bit digit of its result feeds one comparator input.
- Trades latency (one cycle per input bit) for minimal area; uses a start/busy/done handshake.

Parameters:
- BIN_W, 8, width of the binary input in bits (valid range 4..32).
- BCD_DIGITS, 3, number of output BCD digits. Must satisfy 10^BCD_DIGITS > 2^BIN_W-1. If too small, upper digits are lost; no error is flagged.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request conversion; sampled only while idle.
- bin_in  input  BIN_W  binary operand; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out has just been updated.
- bcd_out  output  4*BCD_DIGITS  result; digit k occupies bits [4k+3:4k], with digit 0 the least significant decimal digit.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, bcd_out=0.
  - Internal shift register and bit counter cleared.
  - Takes effect immediately, including mid-conversion. The partial result is discarded and bcd_out reads 0.
- States:
  - IDLE: busy=0. On a clk edge with start=1:
    - latch bin_in into the binary shift register;
    - clear the BCD scratch register;
    - set count=0;
    - go to SHIFT. busy=1 from this edge.
  - SHIFT: one iteration per clock.
    - For every scratch digit >=5, add 3 (4-bit, no carry between digits). All digits are corrected in parallel.
    - Shift the {scratch, binary} concatenation left by 1.
    - Increment count.
  - SHIFT exit: on the edge where count==BIN_W-1 (the BIN_W-th shift):
    - bcd_out <= final scratch value (post-shift);
    - done <= 1, busy <= 0;
    - state <= IDLE.
- done:
  - Registered; high for exactly one cycle, then forced to 0 on the next edge regardless of start.
- Latency:
  - done is high in the cycle beginning BIN_W edges after the accepting edge (8 cycles at default).
  - Minimum start-to-start period is BIN_W+1 cycles.
- Handshake rules:
  - start while busy=1 is ignored (not queued).
  - start held high continuously gives back-to-back conversions, accepted at the edge following each done edge.
  - bin_in changes after the accepting edge do not affect the result in flight.
- bcd_out holding:
  - Holds its last value between conversions.
  - Updates only on the done edge, never with intermediate values.
- Arithmetic:
  - Corrections act only on the scratch digits; the binary field is shifted, never corrected.
  - Correction precedes shift within the same cycle.
  - No digit ever exceeds 9 at the output.
- Edge cases:
  - bin_in=0 gives bcd_out=0 and still takes the full BIN_W cycles.
  - bin_in=2^BIN_W-1 is converted exactly when BCD_DIGITS meets the constraint above.

Test Plan:
1. Defaults, bin_in=8'd255, start pulsed one cycle → busy high 8 cycles; done pulses once 8 edges after the start edge; bcd_out=12'h255.
2. bin_in=0, then 99, then 5, then 10, each with a separate start → bcd_out = 12'h000, 12'h099, 12'h005, 12'h010 in turn; each done is exactly one cycle wide.
3. Start 200; reassert start with bin_in=17 at cycle 3 of busy → ignored; result 12'h200; busy never re-extends.
4. start held high, bin_in=123 → done every 9 cycles; bcd_out=12'h123 each time; busy low exactly one cycle between conversions.
5. Start 255; assert rst asynchronously at cycle 4 → busy, done and bcd_out go to 0 immediately (mid-cycle); next start with 42 after reset release → 12'h042.
6. BIN_W=16, BCD_DIGITS=5; bin_in=65535 → done after 16 cycles; bcd_out=20'h65535. Sweep 0..65535 against a reference model; no digit >9.

Source files
------------

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: serial shift-and-add-3 binary to packed BCD converter.
// Ports: clk, rst (async high), start, bin_in -> busy, done, bcd_out.
module bin2bcd_serial #(
  parameter int BIN_W      = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd_out
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(BIN_W - 1);

  typedef enum logic [0:0] {
    IDLE,
    SHIFT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] scratch_nxt;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             last;

  // Digit correction: every digit >= 5 gets +3
  // in parallel, 4-bit wrap, no inter-digit carry.
  always_comb begin
    adj = scratch;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

  // Shift the corrected scratch left, pulling in
  // the MSB of the binary field.
  assign scratch_nxt =
    {adj[BCD_W-2:0], bin_sr[BIN_W-1]};

  assign last = (state == SHIFT) && (count == LAST);
  assign busy = (state == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sr  <= '0;
      scratch <= '0;
      count   <= '0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      done <= last;
      if (accept) begin
        bin_sr  <= bin_in;
        scratch <= '0;
        count   <= '0;
      end else if (state == SHIFT) begin
        bin_sr  <= bin_sr << 1;
        scratch <= scratch_nxt;
        count   <= count + 1'b1;
      end
      // Only the final post-shift value is published.
      if (last) bcd_out <= scratch_nxt;
    end
  end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// tb_bin2bcd_serial: directed checks of bin2bcd_serial
// at 8-bit defaults and a 16-bit / 5-digit instance.
module tb_bin2bcd_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8;
  logic [7:0]  bin8;
  logic        busy8;
  logic        done8;
  logic [11:0] bcd8;
  logic        start16;
  logic [15:0] bin16;
  logic        busy16;
  logic        done16;
  logic [19:0] bcd16;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bin2bcd_serial #(.BIN_W(8), .BCD_DIGITS(3)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .bin_in(bin8), .busy(busy8), .done(done8),
    .bcd_out(bcd8)
  );

  bin2bcd_serial #(.BIN_W(16), .BCD_DIGITS(5)) u16 (
    .clk(clk), .rst(rst), .start(start16),
    .bin_in(bin16), .busy(busy16), .done(done16),
    .bcd_out(bcd16)
  );

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] exp;
  } vec16_t;

  vec_t   vecs[10];
  vec16_t v16[5];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  // Decimal reference by repeated division.
  function automatic logic [19:0] ref_bcd(
    input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One conversion on the 8-bit instance. If poke>0,
  // start is re-raised with bin=17 at that busy cycle.
  task automatic conv8(input logic [7:0] v,
                       input logic [11:0] exp,
                       input int poke,
                       input string nm);
    int k;
    int bz;
    @(negedge clk);
    bin8 = v;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    bin8 = ~v;
    k = 1;
    bz = 0;
    while (!done8 && k < 40) begin
      if (busy8) bz++;
      if (poke > 0 && k == poke) begin
        start8 = 1'b1;
        bin8 = 8'd17;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start8 = 1'b0;
    check({nm, " latency"}, k - 1, 8);
    check({nm, " busy_cycles"}, bz, 8);
    check({nm, " value"}, bcd8, exp);
    check({nm, " busy_at_done"}, busy8, 0);
    @(negedge clk);
    check({nm, " done_width"}, done8, 0);
    check({nm, " hold"}, bcd8, exp);
  endtask

  task automatic conv16(input logic [15:0] v,
                        input logic [19:0] exp,
                        input string nm);
    int k;
    @(negedge clk);
    bin16 = v;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    k = 1;
    while (!done16 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({nm, " latency"}, k - 1, 16);
    check({nm, " value"}, bcd16, exp);
    for (int d = 0; d < 5; d++)
      if (bcd16[4*d +: 4] > 4'd9)
        check({nm, " digit_range"}, bcd16[4*d +: 4], 9);
    @(negedge clk);
    check({nm, " done_width"}, done16, 0);
  endtask

  initial begin
    int last_d;
    int nd;
    int lows;
    logic [15:0] rv;

    vecs[0] = '{8'd255, 12'h255};
    vecs[1] = '{8'd0,   12'h000};
    vecs[2] = '{8'd99,  12'h099};
    vecs[3] = '{8'd5,   12'h005};
    vecs[4] = '{8'd10,  12'h010};
    vecs[5] = '{8'd1,   12'h001};
    vecs[6] = '{8'd128, 12'h128};
    vecs[7] = '{8'd254, 12'h254};
    vecs[8] = '{8'd64,  12'h064};
    vecs[9] = '{8'd9,   12'h009};

    v16[0] = '{16'd65535, 20'h65535};
    v16[1] = '{16'd0,     20'h00000};
    v16[2] = '{16'd9999,  20'h09999};
    v16[3] = '{16'd10000, 20'h10000};
    v16[4] = '{16'd40960, 20'h40960};

    rst = 1'b1;
    start8 = 1'b0;
    bin8 = '0;
    start16 = 1'b0;
    bin16 = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset bcd", bcd8, 0);
    check("reset bcd16", bcd16, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      conv8(vecs[i].bin, vecs[i].exp, 0,
            $sformatf("vec%0d", i));

    // Start while busy is ignored.
    conv8(8'd200, 12'h200, 3, "ignore_start");
    @(negedge clk);
    check("ignore_start idle", busy8, 0);

    // Start held high: back-to-back conversions.
    @(negedge clk);
    bin8 = 8'd123;
    start8 = 1'b1;
    last_d = -1;
    nd = 0;
    lows = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (!busy8) lows++;
      if (done8) begin
        check("held value", bcd8, 12'h123);
        if (last_d >= 0) begin
          check("held period", c - last_d, 9);
          check("held busy_low", lows, 1);
        end
        last_d = c;
        lows = 0;
        nd++;
        if (nd == 4) begin
          start8 = 1'b0;
          break;
        end
      end
    end
    check("held count", nd, 4);
    @(negedge clk);
    check("held stop", busy8, 0);

    // Asynchronous reset mid-conversion.
    @(negedge clk);
    bin8 = 8'd255;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst busy", busy8, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst busy", busy8, 0);
    check("async_rst done", done8, 0);
    check("async_rst bcd", bcd8, 0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst busy", busy8, 0);
    conv8(8'd42, 12'h042, 0, "after_rst");

    // 16-bit instance.
    for (int i = 0; i < 5; i++)
      conv16(v16[i].bin, v16[i].exp,
             $sformatf("w16_vec%0d", i));
    for (int i = 0; i < 8; i++) begin
      rv = 16'($urandom);
      conv16(rv, ref_bcd(32'(rv)),
             $sformatf("w16_rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
